// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the stage fields the hazard controller observes and the pipeline
// register controls it produces.
//   master : pipeline side (drives stage fields, receives controls)
//   slave  : controller side (receives stage fields, drives controls)
// Parameter CNT_W sets the width of the two performance counters.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Stage fields
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_cnd;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    // Pipeline register controls
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc;
    logic             halted;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_mispred_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, perf_stall_cnt, perf_mispred_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, perf_stall_cnt, perf_mispred_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/bubble control for the Y86-64 five-stage pipeline.
//   - Load/use interlock, mispredicted-jump squash, ret drain (fetch holds
//     until the ret reaches W and W_valM can steer the PC mux), and a sticky
//     halt on any non-AOK status in M or W.
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   ctl    : pipe_hazard_ctrl_if.slave (stage fields in, controls out)
// Parameters:
//   RET_LAT : total F-stall cycles for one ret (2..7)
//   CNT_W   : performance counter width
// Build option:
//   PERF_CNT_EN : when defined, the saturating stall and misprediction
//                 counters are built; otherwise both outputs are tied to 0.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RET_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  ctl
);
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;

    localparam logic [2:0] RET_LOAD = 3'(RET_LAT - 1);

    typedef enum logic [1:0] {RUN, RET, HALT} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic exc, mis, lu, rt;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_en;

    assign exc = (ctl.m_stat != S_AOK) || (ctl.W_stat != S_AOK);
    assign mis = (ctl.E_icode == I_JXX) && !ctl.e_cnd;
    assign lu  = ((ctl.E_icode == I_MRMOVQ) || (ctl.E_icode == I_POPQ)) &&
                 (ctl.E_dstM != RNONE) &&
                 ((ctl.E_dstM == ctl.d_srcA) || (ctl.E_dstM == ctl.d_srcB));
    assign rt  = (ctl.D_icode == I_RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_stall  = 1'b0;
        cc_en    = (ctl.E_icode == I_OPQ) && !exc && (state_q != HALT);

        case (state_q)
            RUN, RET: begin
                if (exc) begin
                    // Freeze everything upstream of the faulting stage; W only
                    // holds if the fault has already reached it. A ret being
                    // drained is abandoned.
                    f_stall  = 1'b1;
                    d_bubble = 1'b1;
                    e_bubble = 1'b1;
                    m_bubble = 1'b1;
                    w_stall  = (ctl.W_stat != S_AOK);
                    state_d  = HALT;
                end else if (state_q == RET) begin
                    // D already holds a bubble and E the ret (or a bubble),
                    // so mis/lu cannot be meaningful here.
                    f_stall  = 1'b1;
                    d_bubble = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end else if (mis) begin
                    d_bubble = 1'b1;
                    e_bubble = 1'b1;
                end else if (lu) begin
                    // A ret waiting in D is simply re-evaluated next cycle.
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    e_bubble = 1'b1;
                end else if (rt) begin
                    f_stall  = 1'b1;
                    d_bubble = 1'b1;
                    state_d  = RET;
                    cnt_d    = RET_LOAD;
                end
            end
            default: begin
                f_stall  = 1'b1;
                d_bubble = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                w_stall  = 1'b1;
            end
        endcase
    end

    // Controls are forced quiet while reset is asserted.
    assign ctl.F_stall  = rst_n & f_stall;
    assign ctl.D_stall  = rst_n & d_stall;
    assign ctl.D_bubble = rst_n & d_bubble;
    assign ctl.E_bubble = rst_n & e_bubble;
    assign ctl.M_bubble = rst_n & m_bubble;
    assign ctl.W_stall  = rst_n & w_stall;
    assign ctl.set_cc   = rst_n & cc_en;
    assign ctl.halted   = (state_q == HALT);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, mispred_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else if (state_q != HALT) begin
            if (f_stall) stall_cnt_q   <= sat_inc(stall_cnt_q);
            if (mis)     mispred_cnt_q <= sat_inc(mispred_cnt_q);
        end
    end

    assign ctl.perf_stall_cnt   = stall_cnt_q;
    assign ctl.perf_mispred_cnt = mispred_cnt_q;
`else
    assign ctl.perf_stall_cnt   = {CNT_W{1'b0}};
    assign ctl.perf_mispred_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic, checked every cycle
// against a behavioural model of the hazard rules (pending-ret countdown,
// sticky halt flag, saturating counters).
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    localparam int RET_LAT = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.RET_LAT(RET_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_halted;
    int m_ret_left;   // remaining RET-drain cycles after the D-cycle
    int m_stall_cnt;
    int m_mis_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic quiet();
        bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
        bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd  = 1'b1;
        bus.m_stat  = 4'h1; bus.W_stat = 4'h1;
    endtask

    task automatic model_reset();
        m_halted = 0; m_ret_left = 0; m_stall_cnt = 0; m_mis_cnt = 0;
    endtask

    // Assert reset mid-cycle and check the immediate effect, then release.
    task automatic do_reset(input string tag);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".F_stall"},  bus.F_stall,  0);
        check({tag, ".D_bubble"}, bus.D_bubble, 0);
        check({tag, ".E_bubble"}, bus.E_bubble, 0);
        check({tag, ".M_bubble"}, bus.M_bubble, 0);
        check({tag, ".W_stall"},  bus.W_stall,  0);
        check({tag, ".halted"},   bus.halted,   0);
        check({tag, ".stall_cnt"}, bus.perf_stall_cnt, 0);
        check({tag, ".mis_cnt"},   bus.perf_mispred_cnt, 0);
        @(negedge clk);
        quiet();
        rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs against the model, then advance.
    task automatic cycle(input string tag);
        bit exc, mis, lu, rt;
        bit eF, eDs, eDb, eEb, eMb, eWs, eCc;
        #2;
        exc = (bus.m_stat != 4'h1) || (bus.W_stat != 4'h1);
        mis = (bus.E_icode == 4'h7) && (bus.e_cnd == 1'b0);
        lu  = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
              (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
        rt  = (bus.D_icode == 4'h9);
        {eF, eDs, eDb, eEb, eMb, eWs} = '0;
        eCc = (bus.E_icode == 4'h6) && !exc && !m_halted;
        if (m_halted) begin
            {eF, eDb, eEb, eMb, eWs} = 5'b11111;
        end else if (exc) begin
            {eF, eDb, eEb, eMb} = 4'b1111;
            eWs = (bus.W_stat != 4'h1);
        end else if (m_ret_left > 0) begin
            {eF, eDb} = 2'b11;
        end else if (mis) begin
            {eDb, eEb} = 2'b11;
        end else if (lu) begin
            {eF, eDs, eEb} = 3'b111;
        end else if (rt) begin
            {eF, eDb} = 2'b11;
        end
        check({tag, ".F_stall"},  bus.F_stall,  eF);
        check({tag, ".D_stall"},  bus.D_stall,  eDs);
        check({tag, ".D_bubble"}, bus.D_bubble, eDb);
        check({tag, ".E_bubble"}, bus.E_bubble, eEb);
        check({tag, ".M_bubble"}, bus.M_bubble, eMb);
        check({tag, ".W_stall"},  bus.W_stall,  eWs);
        check({tag, ".set_cc"},   bus.set_cc,   eCc);
        check({tag, ".halted"},   bus.halted,   m_halted);
        check({tag, ".stall_cnt"}, bus.perf_stall_cnt,   exp_cnt(m_stall_cnt));
        check({tag, ".mis_cnt"},   bus.perf_mispred_cnt, exp_cnt(m_mis_cnt));
        @(posedge clk);
        if (!m_halted) begin
            if (eF && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (mis && m_mis_cnt < CNT_MAX)  m_mis_cnt++;
            if (exc) begin
                m_halted = 1; m_ret_left = 0;
            end else if (m_ret_left > 0) begin
                m_ret_left--;
            end else if (!mis && !lu && rt) begin
                m_ret_left = RET_LAT - 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        int halt_cycles;
        model_reset();
        quiet();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset.halted", bus.halted, 0);
        check("reset.F_stall", bus.F_stall, 0);
        rst_n = 1'b1;

        // Single ret: exactly RET_LAT stall cycles
        bus.D_icode = 4'h9;
        cycle("ret0");
        bus.D_icode = 4'h1;
        for (int i = 0; i < RET_LAT + 2; i++) cycle("ret_drain");
        check("ret.stall_cnt_total", bus.perf_stall_cnt, exp_cnt(RET_LAT));

        // Reset while draining a ret with one cycle left, exc pending
        bus.D_icode = 4'h9;
        cycle("ret1");
        bus.D_icode = 4'h1;
        cycle("ret1_drain");
        bus.m_stat = 4'h3;
        do_reset("rst_mid_ret");

        // Load/use, then the same with no destination
        bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
        cycle("lu_hit");
        bus.E_dstM = 4'hF;
        cycle("lu_none");
        bus.E_icode = 4'hB; bus.E_dstM = 4'h7; bus.d_srcA = 4'hF; bus.d_srcB = 4'h7;
        bus.D_icode = 4'h9;
        cycle("lu_popq_with_ret");
        quiet();
        bus.D_icode = 4'h9;
        cycle("ret_after_lu");
        quiet();
        for (int i = 0; i < RET_LAT; i++) cycle("ret_after_lu_drain");

        // Mispredict squashes a ret in D
        bus.E_icode = 4'h7; bus.e_cnd = 1'b0; bus.D_icode = 4'h9;
        cycle("mis_ret");
        quiet();
        cycle("mis_after");
        check("mis.count", bus.perf_mispred_cnt, exp_cnt(1));

        // Exception during RET with OPq in E, then sticky halt
        bus.D_icode = 4'h9;
        cycle("ret2");
        quiet();
        bus.m_stat = 4'h3; bus.E_icode = 4'h6;
        cycle("exc_in_ret");
        for (int i = 0; i < 10; i++) begin
            bus.m_stat  = 4'($urandom_range(1, 4));
            bus.E_icode = 4'($urandom_range(0, 11));
            bus.D_icode = 4'($urandom_range(0, 11));
            cycle("halt_hold");
        end
        do_reset("rst_halt");

        // Exception reaching W holds W
        bus.W_stat = 4'h2;
        cycle("exc_w");
        do_reset("rst_exc_w");

        // Load/use held long enough to saturate the stall counter
        bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
        for (int i = 0; i < 20; i++) cycle("lu_sat");
        check("lu_sat.final", bus.perf_stall_cnt, exp_cnt(CNT_MAX));
        do_reset("rst_sat");

        // Randomized traffic
        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            bus.D_icode = (r < 3) ? 4'h9 : 4'($urandom_range(0, 11));
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    bus.E_icode = 4'h5;
                2:       bus.E_icode = 4'hB;
                3, 4:    bus.E_icode = 4'h7;
                5:       bus.E_icode = 4'h6;
                default: bus.E_icode = 4'($urandom_range(0, 11));
            endcase
            bus.d_srcA = 4'($urandom_range(0, 15));
            bus.d_srcB = 4'($urandom_range(0, 15));
            bus.E_dstM = ($urandom_range(0, 2) == 0) ? bus.d_srcA : 4'($urandom_range(0, 15));
            bus.e_cnd  = 1'($urandom_range(0, 1));
            bus.m_stat = ($urandom_range(0, 60) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            bus.W_stat = ($urandom_range(0, 80) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            cycle("rand");
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                do_reset("rand_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the Y86-64 five-stage pipeline. It generates the stall and bubble controls for the F/D/E/M/W pipeline registers, and the condition-code write enable.
- Holds a sequential ret-drain FSM, so the fetch stage holds while a ret travels to W, where the fetch PC mux takes W_valM.
- Holds a sticky halt state for exceptions.
- Sits beside the pipeline registers; its decisions depend only on the current-cycle stage fields and its internal state.

Parameters:
RET_LAT, 3, cycles a ret needs to travel from D to W; total F-stall cycles per ret (legal 2..7)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
D_icode  in  4  icode in D register
d_srcA  in  4  decoded srcA (4'hF = RNONE)
d_srcB  in  4  decoded srcB (4'hF = RNONE)
E_icode  in  4  icode in E register
E_dstM  in  4  dstM in E register
e_cnd  in  1  condition result computed in execute
m_stat  in  4  status leaving memory (1=AOK, 2=HLT, 3=ADR, 4=INS)
W_stat  in  4  status in W register
F_stall  out  1  hold F (predPC)
D_stall  out  1  hold D
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W
set_cc  out  1  CC write enable for OPq in E
halted  out  1  sticky halt indicator
perf_stall_cnt  out  CNT_W  count of cycles with F_stall=1
perf_mispred_cnt  out  CNT_W  count of mispredicted jumps

Behaviour:
- Icode values: halt=0, jxx=7, ret=9, mrmovq=5, popq=B, OPq=6.
- Reset (rst_n=0, asynchronous): state=RUN, drain counter=0, halted=0, both perf counters=0. While in reset, all stall/bubble outputs are 0.
- Control outputs are combinational from the inputs and the state. The state updates on posedge clk.
- exc: m_stat!=1 or W_stat!=1.
- mis: E_icode==7 and e_cnd==0.
- lu: E_icode in {5,B}, E_dstM!=F, and E_dstM equals d_srcA or d_srcB.
- rt: D_icode==9.
- set_cc = (E_icode==6) and !exc and state!=HALT.
- Outputs in state RUN, first matching row only:
  1. exc: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, W_stall=(W_stat!=1). Next state HALT.
  2. mis: D_bubble=1, E_bubble=1. Next state RUN.
  3. lu: F_stall=1, D_stall=1, E_bubble=1. Next state RUN. A ret held in D is re-evaluated next cycle.
  4. rt: F_stall=1, D_bubble=1. Next state RET; counter loads RET_LAT-1.
  5. Otherwise all controls are 0.
- State RET:
  - exc follows row 1; next state HALT, and the ret being drained is abandoned.
  - Otherwise F_stall=1, D_bubble=1, and the counter decrements. When the counter is 1 before the edge, next state is RUN.
  - mis and lu are ignored: D holds a bubble and E holds the ret or a bubble.
  - Total stall for one ret is exactly RET_LAT cycles (D-cycle plus RET_LAT-1 RET cycles).
- State HALT: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, W_stall=1, halted=1, set_cc=0. Exit only via rst_n.
- Simultaneous events: exc beats mis beats lu beats rt. A ret in D while a jxx is mispredicted in E is squashed; RET is not entered.
- D_stall and D_bubble are never both 1.
- Perf counters increment on posedge clk when the event holds, except in HALT. They saturate at all-ones.

Optional Feature:
PERF_CNT_EN
- Defined: both perf counters are implemented as above.
- Undefined: no counter flops; perf_stall_cnt and perf_mispred_cnt are tied to 0. All control behaviour is identical.

Test Plan:
1. Reset mid-operation: assert rst_n=0 while in RET with counter=1 → state RUN, F_stall=0, halted=0, counters=0 immediately, with no clock edge.
2. D_icode=9 for one cycle, then D shows a bubble (icode 1), all else quiet, RET_LAT=3 → F_stall=1 and D_bubble=1 for exactly 3 consecutive cycles, then 0. perf_stall_cnt=3.
3. E_icode=5, E_dstM=4'h3, d_srcA=4'h3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Repeat with E_dstM=4'hF → all 0.
4. E_icode=7, e_cnd=0, D_icode=9 together → D_bubble=1, E_bubble=1, F_stall=0. Next cycle state is RUN. perf_mispred_cnt=1.
5. m_stat=3 during RET with E_icode=6 → set_cc=0, M_bubble=1. Next cycle halted=1 with all freeze outputs 1. This persists for 10 cycles until rst_n=0.
6. With PERF_CNT_EN and CNT_W=4, hold lu for 20 cycles → perf_stall_cnt saturates at 4'hF.
